// File: rtl/alu_pkg.sv
// Shared ALU definitions: fixed-point result format and the result record
// that travels from the ALU into downstream buffering.
package alu_pkg;

  localparam int INT_W  = 7;
  localparam int FRAC_W = 5;
  localparam int INST_W = 3;
  localparam int DATA_W = INT_W + FRAC_W;

  // One ALU result: overflow flag plus signed Q7.5 value.
  typedef struct packed {
    logic                     ovf;
    logic signed [DATA_W-1:0] data;
  } alu_res_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear. Clear has priority over
// increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/alu_result_buffer.sv
// First-word-fall-through buffer for ALU results. The ALU cannot be stalled,
// so a result arriving while the buffer is full is dropped and counted.
//
// Handshake: the head entry is transferred on every rising edge where
// o_valid and i_ready are both high. o_valid never depends on i_ready, and
// while o_valid is high the head stays stable until it is transferred.
// On the input side i_valid is a plain strobe with no ready; a full buffer
// still accepts the result if the head is leaving in the same cycle.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_overflow,
  input  logic                     i_ready,
  input  logic                     i_clr_stat,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_overflow,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_drop_cnt,
  output logic [CNT_W-1:0]         o_ovf_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_OW = PTR_W + 1;

  // Storage word: overflow flag in the MSB, result below it.
  logic [DATA_W:0]  mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_OW-1:0] count_q,  count_d;

  logic push;
  logic pop;
  logic drop;
  logic [DATA_W:0] head;

  // Status flags come only from the registered count.
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_OW'(DEPTH));
  assign o_valid = ~o_empty;
  assign o_count = count_q;

  assign pop  = o_valid & i_ready;
  assign push = i_valid & (~o_full | pop);
  assign drop = i_valid & o_full & ~pop;

  // Head is masked so stale memory never leaks out after reset or drain.
  assign head       = mem_q[rd_ptr_q];
  assign o_data     = o_valid ? head[DATA_W-1:0] : '0;
  assign o_overflow = o_valid & head[DATA_W];

  // Pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_OW'(1);
      2'b01:   count_d = count_q - CNT_OW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every stored entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage, written bit-exact; contents need no reset since reads are masked.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_overflow, i_data};
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (drop),
    .i_clr   (i_clr_stat),
    .o_cnt   (o_drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (push & i_overflow),
    .i_clr   (i_clr_stat),
    .o_cnt   (o_ovf_cnt)
  );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic          valid   = 1'b0;
  logic [DW-1:0] data    = '0;
  logic          ovf     = 1'b0;
  logic          ready   = 1'b0;
  logic          clr     = 1'b0;

  logic          o_valid, o_overflow, o_full, o_empty;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic [7:0]    o_drop_cnt, o_ovf_cnt;

  logic          o2_valid, o2_overflow, o2_full, o2_empty;
  logic [DW-1:0] o2_data;
  logic [CW-1:0] o2_count;
  logic [1:0]    o2_drop_cnt, o2_ovf_cnt;

  alu_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .i_overflow(ovf), .i_ready(ready), .i_clr_stat(clr),
    .o_valid(o_valid), .o_data(o_data), .o_overflow(o_overflow),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  // Narrow-counter instance sharing all stimulus, for saturation at 3.
  alu_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .i_overflow(ovf), .i_ready(ready), .i_clr_stat(clr),
    .o_valid(o2_valid), .o_data(o2_data), .o_overflow(o2_overflow),
    .o_full(o2_full), .o_empty(o2_empty), .o_count(o2_count),
    .o_drop_cnt(o2_drop_cnt), .o_ovf_cnt(o2_ovf_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW:0] exp_q[$];
  int  m_drop, m_ovf, m_drop2, m_ovf2;
  bit  m_known = 1'b0;
  bit  m_full, m_pop, m_push, m_drop_ev;

  // Monitor: at the falling edge compare DUT state with the model, then
  // advance the model by what the upcoming rising edge will do.
  always @(negedge clk) begin
    if (m_known) begin
      check("valid",    32'(o_valid),    32'(exp_q.size() != 0));
      check("empty",    32'(o_empty),    32'(exp_q.size() == 0));
      check("full",     32'(o_full),     32'(exp_q.size() == DEPTH));
      check("count",    32'(o_count),    32'(exp_q.size()));
      check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
      check("ovf_cnt",  32'(o_ovf_cnt),  32'(m_ovf));
      check("drop_cnt2", 32'(o2_drop_cnt), 32'(m_drop2));
      check("ovf_cnt2",  32'(o2_ovf_cnt),  32'(m_ovf2));
      if (exp_q.size() != 0) begin
        check("head_data", 32'(o_data),     32'(exp_q[0][DW-1:0]));
        check("head_ovf",  32'(o_overflow), 32'(exp_q[0][DW]));
        check("head_data2", 32'(o2_data),   32'(exp_q[0][DW-1:0]));
      end else begin
        check("idle_data", 32'(o_data),     32'(0));
        check("idle_ovf",  32'(o_overflow), 32'(0));
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      m_drop = 0; m_ovf = 0; m_drop2 = 0; m_ovf2 = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_full    = (exp_q.size() == DEPTH);
      m_pop     = (exp_q.size() != 0) && ready;
      m_push    = valid && (!m_full || m_pop);
      m_drop_ev = valid && m_full && !m_pop;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({ovf, data});
      if (clr) begin
        m_drop = 0; m_ovf = 0; m_drop2 = 0; m_ovf2 = 0;
      end else begin
        if (m_drop_ev) begin
          m_drop  = (m_drop  < 255) ? m_drop  + 1 : 255;
          m_drop2 = (m_drop2 < 3)   ? m_drop2 + 1 : 3;
        end
        if (m_push && ovf) begin
          m_ovf  = (m_ovf  < 255) ? m_ovf  + 1 : 255;
          m_ovf2 = (m_ovf2 < 3)   ? m_ovf2 + 1 : 3;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [DW-1:0] d, input bit o,
                      input bit r, input bit c);
    valid = v; data = d; ovf = o; ready = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, r, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b0, 1);

    // Single push, held, then consumed.
    step(1'b1, 12'h0A0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 2);

    // Fill to full, one dropped push, then drain.
    for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 10);

    // Full plus simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h5A5, 1'b1, 1'b1, 1'b0);
    step(1'b1, 12'h3C3, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 10);

    // Overflow counting, clear coinciding with a fourth overflow push.
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    step(1'b1, 12'h7FF, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    idle(1'b1, 2);
    rst_n = 1'b0;
    idle(1'b1, 1);
    rst_n = 1'b1;
    idle(1'b1, 2);

    // Drops past both counter limits (3 for the narrow one, 255 for the wide).
    for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), 1'(i & 1), 1'b0, 1'b0);
    idle(1'b1, 10);

    // Random traffic with occasional stat clears.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
    end
    idle(1'b1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
